// File: rtl/spi_sram_bridge_pkg.sv
// Shared constants, state encoding and frame builder for the SPI SRAM bridge.
package spi_sram_bridge_pkg;

    localparam logic [7:0] SPI_CMD_READ   = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
    localparam int         SPI_FRAME_BITS = 48;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SHIFT  = 3'd2,
        FINISH = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Builds {cmd, byte address, data}. The byte address is {8'h00, word, 1'b0}
    // and a read shifts zeros out during its data phase.
    function automatic logic [47:0] build_frame(input logic       we,
                                                input logic [14:0] addr,
                                                input logic [15:0] data);
        logic [7:0]  cmd;
        logic [15:0] payload;
        cmd     = we ? SPI_CMD_WRITE : SPI_CMD_READ;
        payload = we ? data : 16'h0000;
        return {cmd, 8'h00, addr, 1'b0, payload};
    endfunction

endpackage

// File: rtl/spi_sram_bridge_shifter.sv
// SPI mode 0 frame engine: clock divider, 48-bit shift register, bit counter.
// After load, one cycle passes with CS low and bit 47 on MOSI, then 48 bits are
// clocked, each lasting 2*CLOCK_DIV cycles. MISO is captured on the rising
// spi_clk, MOSI advances on the falling spi_clk. done_pulse is combinational and
// marks the edge that produces the 48th falling spi_clk.
module spi_shifter
    import spi_sram_bridge_pkg::*;
#(
    parameter int CLOCK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [47:0] frame,
    output logic        active,
    output logic        done_pulse,
    output logic [15:0] rx_word,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    logic [47:0] shreg;
    logic [5:0]  bit_cnt;
    logic [7:0]  div_cnt;
    logic        pending;
    logic        tick;
    logic        fall;

    assign tick       = active && (div_cnt == 8'(CLOCK_DIV - 1));
    assign fall       = tick && spi_clk;
    assign done_pulse = fall && (bit_cnt == 6'(SPI_FRAME_BITS - 1));

    // Frame sequencing: load, one setup cycle, then divided shifting until the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            pending  <= 1'b0;
            active   <= 1'b0;
            rx_word  <= '0;
            spi_cs   <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else if (load) begin
            shreg    <= frame;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            pending  <= 1'b1;
            active   <= 1'b0;
            spi_cs   <= 1'b0;
            spi_clk  <= 1'b0;
            spi_mosi <= frame[47];
        end else if (pending) begin
            pending <= 1'b0;
            active  <= 1'b1;
            div_cnt <= '0;
        end else if (active) begin
            if (tick) begin
                div_cnt <= '0;
                spi_clk <= ~spi_clk;
                if (!spi_clk) begin
                    rx_word <= {rx_word[14:0], spi_miso};
                end else begin
                    shreg    <= {shreg[46:0], 1'b0};
                    spi_mosi <= shreg[46];
                    bit_cnt  <= bit_cnt + 6'd1;
                    if (done_pulse) begin
                        active   <= 1'b0;
                        spi_cs   <= 1'b1;
                        spi_mosi <= 1'b0;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/spi_sram_bridge.sv
// Bridges a 16-bit word bus bank onto an external SPI SRAM. One bus access is
// one SPI transaction; the CPU is held with ready=0 until it completes.
//
// Handshake (four-phase): the master raises bus_enable with address, data_in and
// write_enable stable; they are captured on that edge and ignored afterwards.
// ready rises when the transaction is complete and stays high until bus_enable
// falls; a new request is only accepted after bus_enable has been low for a cycle.
// CLOCK_DIV must lie in 1..255.
module spi_sram_bridge
    import spi_sram_bridge_pkg::*;
#(
    parameter int CLOCK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] address,
    input  logic [15:0] data_in,
    input  logic        write_enable,
    input  logic        bus_enable,
    output logic [15:0] data_out,
    output logic        ready,
    output logic        busy,
    output logic        spi_cs,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output state_t      state
);

    logic        load;
    logic        shift_active;
    logic        done_pulse;
    logic [15:0] rx_word;
    logic        is_read;

    assign load = (state == IDLE) && bus_enable && !shift_active;

    spi_shifter #(.CLOCK_DIV(CLOCK_DIV)) u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .frame      (build_frame(write_enable, address, data_in)),
        .active     (shift_active),
        .done_pulse (done_pulse),
        .rx_word    (rx_word),
        .spi_cs     (spi_cs),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
    );

    // Handshake FSM with registered ready, busy and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            data_out <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            is_read  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load) begin
                        state   <= START;
                        busy    <= 1'b1;
                        is_read <= !write_enable;
                    end
                end
                START: state <= SHIFT;
                SHIFT: begin
                    if (done_pulse) state <= FINISH;
                end
                FINISH: begin
                    state <= DONE;
                    ready <= 1'b1;
                    if (is_read) data_out <= rx_word;
                end
                DONE: begin
                    if (!bus_enable) begin
                        state <= IDLE;
                        ready <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
